regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Writer end of the register file's single write port.
- Accepts write-back requests from two producers:
  - port A: ALU/load write-back, single-cycle.
  - port B: long-latency unit (mult/div).
- Buffers requests in a small in-order queue and drains one per cycle onto the register file's write port (we, waddr, wdata).
- Provides a two-port bypass lookup so decode reads see writes still pending in the queue.

Parameters:
- AddrL, 5, register address width.
- WL, 32, data word width.
- Depth, 4, queue entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- a_valid  input  1  producer A has a write request.
- a_ready  output  1  producer A request accepted this cycle.
- a_addr  input  AddrL  producer A destination register.
- a_data  input  WL  producer A data.
- b_valid  input  1  producer B has a write request.
- b_ready  output  1  producer B request accepted this cycle.
- b_addr  input  AddrL  producer B destination register.
- b_data  input  WL  producer B data.
- hold  input  1  suppress drain this cycle.
- rf_we  output  1  register file write enable.
- rf_waddr  output  AddrL  register file write address.
- rf_wdata  output  WL  register file write data.
- lk_addr1  input  AddrL  bypass lookup address 1.
- lk_addr2  input  AddrL  bypass lookup address 2.
- lk_hit1  output  1  lookup 1 matches a pending entry.
- lk_hit2  output  1  lookup 2 matches a pending entry.
- lk_data1  output  WL  youngest pending data for lookup 1.
- lk_data2  output  WL  youngest pending data for lookup 2.
- busy  output  1  queue non-empty.

Behaviour:
- Reset (rst low, asynchronous):
  - Queue emptied, pointers and count cleared.
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, lk_hit*=0, lk_data*=0.
  - a_ready=0 and b_ready=0 while rst is low.
  - Reset mid-operation discards all pending entries; they are never written.
- Transfer happens on a rising edge where valid & ready.
- Readiness:
  - Ready is combinational from the registered count and the current valids; it does not count a same-cycle drain.
  - a_ready = (free >= 1).
  - b_ready = (free >= 2) | ((free == 1) & ~a_valid).
  - Producer A has priority when only one slot is free.
- Same-cycle acceptance: if A and B are both accepted, A's entry is enqueued older than B's (two slots written in one edge).
- Register 0:
  - A request with addr == 0 is accepted (ready as above) but not enqueued and occupies no slot.
  - Its slot is still counted for the readiness calculation.
- Drain:
  - rf_we = busy & ~hold.
  - rf_waddr and rf_wdata come combinationally from the queue head.
  - Head is popped on the edge where rf_we=1.
- Latency: a request accepted at edge N appears on rf_* in cycle N+1 at the earliest and is written into the register file at edge N+1.
- Simultaneous events: enqueue and drain in the same edge are both applied; count' = count + pushes - pop.
- Full: count == Depth ⇒ a_ready = b_ready = 0; hold=1 indefinitely keeps the queue full with no loss.
- Wrap-around: pointers are log2(Depth) bits and wrap modulo Depth; count is log2(Depth)+1 bits.
- Bypass lookup:
  - Combinational over valid entries only; excludes the requests arriving this cycle.
  - The youngest matching entry wins.
  - lk_addr == 0 always gives hit=0, data=0.
  - No match gives hit=0, data=0.
- Ordering: register file writes occur strictly in acceptance order, so the final value is the youngest write.

Optional Feature:
- Macro: REGFILE_WRITE_ARBITER_STATS_EN.
- With it defined, adds output port stall_cnt (16 bits):
  - Increments each cycle in which (a_valid & ~a_ready) | (b_valid & ~b_ready).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Without it: no port and no counter logic; behaviour otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - ADDR_L=5 and WL=32 constants.
  - wb_entry_t {addr, data}.
- Natural sub-module: wb_queue.
  - Circular buffer with two-push/one-pop, count, and head outputs.
  - Exposes entry and valid vectors for the lookup logic.
- Arbitration and youngest-match lookup stay in the top module.

Test Plan:
- Single write: A (addr 5, 32'hDEAD_BEEF), hold=0 → next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF; busy=0 after the drain edge.
- Dual push: A (3, 1) and B (3, 2) in the same cycle, Depth=4, empty → both ready; rf_* shows (3,1) then (3,2); lk_addr1=3 gives data 2 after enqueue.
- Full/priority: hold=1, fill to 3 entries, then A and B both valid → a_ready=1, b_ready=0; next cycle full, both ready=0; release hold → drains 4 entries in order over 4 cycles.
- Register 0: A (0, 32'h1234) → a_ready=1, busy stays 0, rf_we stays 0, lk_addr=0 gives hit=0.
- Reset mid-operation: 2 entries pending, pull rst low asynchronously → rf_we=0 immediately; after release busy=0 and the old entries are never written.
- Stats (macro on): hold=1, queue full, A valid for 10 cycles → stall_cnt=10.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared register-file widths and the write-back entry type.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam int ADDR_L = 5;
    localparam int WL     = 32;

    typedef struct packed {
        logic [ADDR_L-1:0] addr;
        logic [WL-1:0]     data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Brief    : In-order circular write-back buffer, two pushes and one pop per
//            cycle, with every slot and its valid bit exposed for lookups.
// Revision : 1.0
// ============================================================================
module wb_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push0,
    input  wb_entry_t                     ent0,
    input  logic                          push1,
    input  wb_entry_t                     ent1,
    input  logic                          pop,
    output logic [$clog2(DEPTH):0]        count,
    output logic [$clog2(DEPTH)-1:0]      rd_ptr,
    output wb_entry_t                     head,
    output wb_entry_t [DEPTH-1:0]         entries,
    output logic [DEPTH-1:0]              valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] r_ent;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         w_wr_ptr1;

    // The second push lands behind the first only when the first is present.
    assign w_wr_ptr1 = r_wr_ptr + PW'(push0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ent    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push0) begin
                r_ent[r_wr_ptr] <= ent0;
            end
            if (push1) begin
                r_ent[w_wr_ptr1] <= ent1;
            end
            r_wr_ptr <= r_wr_ptr + PW'(push0) + PW'(push1);
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PW-1:0] w_off;
        assign w_off    = PW'(i) - r_rd_ptr;
        assign valid[i] = ({1'b0, w_off} < r_count);
    end

    assign count   = r_count;
    assign rd_ptr  = r_rd_ptr;
    assign head    = r_ent[r_rd_ptr];
    assign entries = r_ent;

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Two-producer write-back arbiter feeding the single RF write port,
//            with youngest-match bypass lookup over pending entries.
//            Optional stall counter: REGFILE_WRITE_ARBITER_STATS_EN.
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_L-1:0] a_addr,
    input  logic [WL-1:0]     a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_L-1:0] b_addr,
    input  logic [WL-1:0]     b_data,
    input  logic              hold,
    output logic              rf_we,
    output logic [ADDR_L-1:0] rf_waddr,
    output logic [WL-1:0]     rf_wdata,
    input  logic [ADDR_L-1:0] lk_addr1,
    input  logic [ADDR_L-1:0] lk_addr2,
    output logic              lk_hit1,
    output logic              lk_hit2,
    output logic [WL-1:0]     lk_data1,
    output logic [WL-1:0]     lk_data2,
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              busy
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_free;
    logic [PW-1:0]         w_rd_ptr;
    wb_entry_t             w_head;
    wb_entry_t [DEPTH-1:0] w_entries;
    logic [DEPTH-1:0]      w_valid;
    logic                  w_push_a;
    logic                  w_push_b;
    wb_entry_t             w_ent_a;
    wb_entry_t             w_ent_b;

    assign w_free  = C_DEPTH - w_count;
    assign a_ready = rst & (w_free != '0);
    assign b_ready = rst & ((w_free >= CW'(2)) | ((w_free == CW'(1)) & ~a_valid));

    // Register 0 writes are accepted and dropped; they never occupy a slot.
    assign w_push_a = a_valid & a_ready & (a_addr != '0);
    assign w_push_b = b_valid & b_ready & (b_addr != '0);
    assign w_ent_a  = '{addr: a_addr, data: a_data};
    assign w_ent_b  = '{addr: b_addr, data: b_data};

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push0   (w_push_a),
        .ent0    (w_ent_a),
        .push1   (w_push_b),
        .ent1    (w_ent_b),
        .pop     (rf_we),
        .count   (w_count),
        .rd_ptr  (w_rd_ptr),
        .head    (w_head),
        .entries (w_entries),
        .valid   (w_valid)
    );

    assign busy     = (w_count != '0);
    assign rf_we    = busy & ~hold;
    assign rf_waddr = busy ? w_head.addr : '0;
    assign rf_wdata = busy ? w_head.data : '0;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        lk_hit1  = 1'b0;
        lk_data1 = '0;
        lk_hit2  = 1'b0;
        lk_data2 = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_rd_ptr + PW'(k);
            if (w_valid[idx] && (lk_addr1 != '0) && (w_entries[idx].addr == lk_addr1)) begin
                lk_hit1  = 1'b1;
                lk_data1 = w_entries[idx].data;
            end
            if (w_valid[idx] && (lk_addr2 != '0) && (w_entries[idx].addr == lk_addr2)) begin
                lk_hit2  = 1'b1;
                lk_data2 = w_entries[idx].data;
            end
        end
    end

`ifdef REGFILE_WRITE_ARBITER_STATS_EN
    logic        w_stall;
    logic [15:0] r_stall_cnt;

    assign w_stall = (a_valid & ~a_ready) | (b_valid & ~b_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
